// File: rtl/dac_button_ctrl_if.sv
// Handshake between the button controller and the DAC SPI writer.
interface dac_button_ctrl_if #(
  parameter int unsigned WIDTH = 12
);
  logic             dac_start;
  logic [WIDTH-1:0] dac_data;
  logic             dac_busy;

  modport master (output dac_start, output dac_data, input dac_busy);
  modport slave  (input dac_start, input dac_data, output dac_busy);
endinterface

// File: rtl/dac_button_ctrl.sv
// Button conditioning (sync, debounce, press detect), saturating DAC code
// stepping and start/busy handshake towards the DAC SPI writer.
module dac_button_ctrl #(
  parameter int unsigned           WIDTH           = 12,
  parameter int unsigned           STEP            = 256,
  parameter logic [WIDTH-1:0]      INIT_VALUE      = WIDTH'(12'h800),
  parameter int unsigned           DEBOUNCE_CYCLES = 16
) (
  input  logic                     CLK50MHZ,
  input  logic                     RST,
  input  logic                     BTN_WEST,
  input  logic                     BTN_EAST,
  dac_button_ctrl_if.master        dac,
  output logic [WIDTH-1:0]         value,
  output logic                     west_press,
  output logic                     east_press
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  // Bit 0 is the west button, bit 1 the east button.
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       stable_q, stable_d, prev_q, prev_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic [WIDTH-1:0] value_q, value_d, data_q, data_d;
  logic [WIDTH:0]   sum;
  logic             req;

  logic [1:0]       state_q, state_d, tmo_q, tmo_d;
  logic             start_q, start_d, seen_q, seen_d, pend_q, pend_d;
  logic             done;

  // Synchronise, debounce and edge-detect both buttons.
  always_comb begin
    sync1_d  = {BTN_EAST, BTN_WEST};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    press_d  = stable_q & ~prev_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Saturating step of the DAC code; simultaneous presses cancel.
  always_comb begin
    req     = press_q[0] ^ press_q[1];
    sum     = {1'b0, value_q} + (WIDTH + 1)'(STEP);
    value_d = value_q;
    if (press_q[1] && !press_q[0]) begin
      value_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end else if (press_q[0] && !press_q[1]) begin
      value_d = (value_q < WIDTH'(STEP)) ? '0 : value_q - WIDTH'(STEP);
    end
  end

  // Write request FSM: one start per write, never while the writer is busy.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    tmo_d   = tmo_q;
    seen_d  = seen_q;
    pend_d  = pend_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!dac.dac_busy) begin
            start_d = 1'b1;
            data_d  = value_d;
            state_d = ST_BUSY;
            tmo_d   = '0;
            seen_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!dac.dac_busy) begin
          start_d = 1'b1;
          data_d  = value_d;
          state_d = ST_BUSY;
          tmo_d   = '0;
          seen_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        pend_d = pend_q | req;
        if (!seen_q) begin
          if (dac.dac_busy) begin
            seen_d = 1'b1;
          end else if (tmo_q == 2'd3) begin
            done = 1'b1;
          end else begin
            tmo_d = tmo_q + 2'd1;
          end
        end else if (!dac.dac_busy) begin
          done = 1'b1;
        end
        if (done) begin
          state_d = (pend_q | req) ? ST_PEND : ST_IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      press_q  <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      value_q  <= INIT_VALUE;
      data_q   <= INIT_VALUE;
      start_q  <= 1'b0;
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      seen_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      value_q  <= value_d;
      data_q   <= data_d;
      start_q  <= start_d;
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      pend_q   <= pend_d;
    end
  end

  assign dac.dac_start = start_q;
  assign dac.dac_data  = data_q;
  assign value         = value_q;
  assign west_press    = press_q[0];
  assign east_press    = press_q[1];

endmodule

// File: tb/tb_dac_button_ctrl.sv
// Self-checking bench for dac_button_ctrl: directed scenarios plus a
// randomized press sequence checked against an arithmetic value model.
module tb_dac_button_ctrl;

  localparam int D = 16;

  logic        clk;
  logic        rst;
  logic        btn_w;
  logic        btn_e;
  logic [11:0] value;
  logic        wp;
  logic        ep;

  dac_button_ctrl_if #(.WIDTH(12)) dac_if ();

  dac_button_ctrl #(
    .WIDTH(12), .STEP(256), .INIT_VALUE(12'h800), .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK50MHZ(clk), .RST(rst), .BTN_WEST(btn_w), .BTN_EAST(btn_e),
    .dac(dac_if.master), .value(value), .west_press(wp), .east_press(ep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          tick_no = 0;
  int          n_wp = 0, n_ep = 0, n_st = 0, n_both = 0;
  int          last_ep_tick = 0, last_st_tick = 0;
  logic [11:0] last_data = '0;
  bit          force_busy = 0;
  bit          wr_en = 0;
  int          wr_cnt = 0;
  int          model_val = 2048;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected code after one press event, from the stepping rules.
  function automatic int model_step(input int v, input bit w, input bit e);
    int r;
    r = v;
    if (e && !w) r = (v + 256 > 4095) ? 4095 : v + 256;
    if (w && !e) r = (v - 256 < 0) ? 0 : v - 256;
    return r;
  endfunction

  // One clock: drive busy at negedge, sample outputs 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    dac_if.dac_busy = force_busy || (wr_cnt > 0);
    if (wr_cnt > 0) wr_cnt--;
    @(posedge clk);
    #1;
    tick_no++;
    if (wp) n_wp++;
    if (ep) begin
      n_ep++;
      last_ep_tick = tick_no;
    end
    if (wp && ep) n_both++;
    if (dac_if.dac_start) begin
      n_st++;
      last_data = dac_if.dac_data;
      last_st_tick = tick_no;
      check("start_while_busy", 32'(dac_if.dac_busy), 0);
      if (wr_en) wr_cnt = $urandom_range(1, 5);
    end
  endtask

  task automatic do_reset();
    btn_w = 0;
    btn_e = 0;
    force_busy = 0;
    wr_cnt = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    model_val = 2048;
  endtask

  // One press (or simultaneous press) with random-length hold and release.
  task automatic press(input bit w, input bit e);
    int st0, wp0, ep0, hold, rel;
    st0 = n_st;
    wp0 = n_wp;
    ep0 = n_ep;
    hold = $urandom_range(D + 4, 3 * D);
    rel  = $urandom_range(D + 6, 2 * D + 6);
    btn_w = w;
    btn_e = e;
    repeat (hold) tick();
    btn_w = 0;
    btn_e = 0;
    repeat (rel) tick();
    model_val = model_step(model_val, w, e);
    check("west_pulses", 32'(n_wp - wp0), 32'(w));
    check("east_pulses", 32'(n_ep - ep0), 32'(e));
    check("value", 32'(value), 32'(model_val));
    if (!force_busy) begin
      check("starts", 32'(n_st - st0), 32'(w ^ e));
      if (w ^ e) check("start_data", 32'(last_data), 32'(model_val));
    end
  endtask

  // A high pulse shorter than the debounce window must be ignored.
  task automatic glitch(input bit w, input bit e, input int len);
    int st0, wp0, ep0;
    st0 = n_st;
    wp0 = n_wp;
    ep0 = n_ep;
    btn_w = w;
    btn_e = e;
    repeat (len) tick();
    btn_w = 0;
    btn_e = 0;
    repeat (D + 4) tick();
    check("glitch_pulses", 32'((n_wp - wp0) + (n_ep - ep0)), 0);
    check("glitch_starts", 32'(n_st - st0), 0);
    check("glitch_value", 32'(value), 32'(model_val));
  endtask

  initial begin
    int t0, st0, wp0, ep0, r;
    rst = 1;
    btn_w = 0;
    btn_e = 0;
    dac_if.dac_busy = 0;

    // Reset state
    do_reset();
    check("rst_value", 32'(value), 32'h800);
    check("rst_data", 32'(dac_if.dac_data), 32'h800);
    check("rst_start", 32'(dac_if.dac_start), 0);
    check("rst_press", 32'({wp, ep}), 0);

    // East held 50 cycles: one pulse, latency, one start
    wr_en = 1;
    t0 = tick_no;
    st0 = n_st;
    ep0 = n_ep;
    btn_e = 1;
    repeat (50) tick();
    btn_e = 0;
    repeat (30) tick();
    check("east_once", 32'(n_ep - ep0), 1);
    check("east_latency", 32'(last_ep_tick - t0), 32'(D + 3));
    check("start_once", 32'(n_st - st0), 1);
    check("start_latency", 32'(last_st_tick - t0), 32'(D + 4));
    check("start_data_900", 32'(last_data), 32'h900);
    check("value_900", 32'(value), 32'h900);

    // West glitch pattern 10 high / 5 low / 10 high
    do_reset();
    st0 = n_st;
    wp0 = n_wp;
    btn_w = 1; repeat (10) tick();
    btn_w = 0; repeat (5) tick();
    btn_w = 1; repeat (10) tick();
    btn_w = 0; repeat (30) tick();
    check("glitch_west", 32'(n_wp - wp0), 0);
    check("glitch_start", 32'(n_st - st0), 0);
    check("glitch_value800", 32'(value), 32'h800);

    // Saturation up then down
    do_reset();
    for (int i = 0; i < 13; i++) press(0, 1);
    check("sat_high", 32'(value), 32'hFFF);
    for (int i = 0; i < 16; i++) press(1, 0);
    check("sat_low", 32'(value), 32'h000);

    // Busy held across three presses: one coalesced write
    do_reset();
    force_busy = 1;
    st0 = n_st;
    for (int i = 0; i < 3; i++) press(1, 0);
    check("busy_value", 32'(value), 32'h500);
    check("busy_no_start", 32'(n_st - st0), 0);
    force_busy = 0;
    repeat (20) tick();
    check("busy_one_start", 32'(n_st - st0), 1);
    check("busy_data", 32'(last_data), 32'h500);

    // Both buttons together
    do_reset();
    st0 = n_st;
    wp0 = n_wp;
    ep0 = n_ep;
    r = n_both;
    btn_w = 1;
    btn_e = 1;
    repeat (50) tick();
    btn_w = 0;
    btn_e = 0;
    repeat (30) tick();
    check("both_coincide", 32'(n_both - r), 1);
    check("both_west", 32'(n_wp - wp0), 1);
    check("both_east", 32'(n_ep - ep0), 1);
    check("both_value", 32'(value), 32'h800);
    check("both_no_start", 32'(n_st - st0), 0);

    // Reset mid-debounce, then debounce restarts from zero
    do_reset();
    btn_e = 1;
    repeat (8) tick();
    rst = 1;
    tick();
    rst = 0;
    model_val = 2048;
    check("mid_rst_value", 32'(value), 32'h800);
    check("mid_rst_data", 32'(dac_if.dac_data), 32'h800);
    check("mid_rst_out", 32'({dac_if.dac_start, wp, ep}), 0);
    ep0 = n_ep;
    repeat (D + 2) tick();
    check("mid_rst_no_early", 32'(n_ep - ep0), 0);
    tick();
    check("mid_rst_pulse", 32'(ep), 1);
    btn_e = 0;
    repeat (30) tick();
    model_val = model_step(model_val, 0, 1);
    check("mid_rst_after", 32'(value), 32'(model_val));

    // Reset while a write is pending: request dropped
    force_busy = 1;
    press(1, 0);
    rst = 1;
    tick();
    rst = 0;
    force_busy = 0;
    model_val = 2048;
    st0 = n_st;
    repeat (30) tick();
    check("pend_rst_no_start", 32'(n_st - st0), 0);
    check("pend_rst_value", 32'(value), 32'h800);
    check("pend_rst_data", 32'(dac_if.dac_data), 32'h800);

    // Randomized presses, glitches and writer behaviour
    do_reset();
    for (int i = 0; i < 24; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 11);
      if (r < 4)       press(1, 0);
      else if (r < 8)  press(0, 1);
      else if (r < 9)  press(1, 1);
      else             glitch(r[0], !r[0], $urandom_range(1, D - 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_button_ctrl.md
Name: dac_button_ctrl

Overview:
- Receiving end of the push-button stimulus for the DAC demo. Conditions BTN_WEST and BTN_EAST by synchronising, debouncing and detecting presses.
- Each accepted press steps a 12-bit DAC code down (west) or up (east), with saturation at both ends.
- Issues a start strobe to the downstream DAC SPI writer, honouring that writer's busy handshake. Sits between the board button pins and the DAC serial transmitter.

Parameters:
- WIDTH, 12, width of the DAC code.
- STEP, 256, amount added or subtracted per accepted press.
- INIT_VALUE, 12'h800, DAC code loaded on reset.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised level must hold before it is accepted (>=2). Board builds override this to 500000 (10 ms).

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz.
- RST  input  1  synchronous, active-high reset.
- BTN_WEST  input  1  raw asynchronous button, active high; press = decrement.
- BTN_EAST  input  1  raw asynchronous button, active high; press = increment.
- dac_busy  input  1  high while the SPI writer is shifting a word.
- dac_start  output  1  one-cycle strobe requesting a DAC write of dac_data.
- dac_data  output  WIDTH  code to write; stable from dac_start until dac_busy falls.
- value  output  WIDTH  current DAC code (updates immediately on a press).
- west_press  output  1  one-cycle pulse per accepted west press.
- east_press  output  1  one-cycle pulse per accepted east press.

Behaviour:
Reset (RST high at a rising edge):
- Synchronisers, debounce counters and stable levels clear to 0.
- value = dac_data = INIT_VALUE.
- dac_start, west_press and east_press = 0.
- FSM goes to IDLE.
- No write is issued after reset. Reset mid-debounce or mid-transaction abandons it; a pending request is dropped.

Synchronisation:
- Two flip-flop synchroniser per button, so there are 2 cycles of latency to the synchronised signal.

Debounce (per button):
- When the synchronised level differs from the stable level, the counter increments. When they are equal, the counter clears to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable level takes the synchronised value and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES is therefore ignored. Release is debounced identically.

Press detect:
- west_press / east_press pulse for exactly one cycle, the cycle after the stable level rises 0->1.
- No pulse on release. Holding a button gives exactly one pulse (no auto-repeat).

Value update (cycle after the press pulse):
- West only: value = value - STEP, saturating at 0.
- East only: value = value + STEP, saturating at 2^WIDTH-1. Compute in WIDTH+1 bits to detect overflow.
- Both pulses in the same cycle: no change and no request.
- A saturated press that leaves value unchanged still counts as a change request (it rewrites the same code).

Output FSM (IDLE, PEND, BUSY):
- IDLE: on a change request:
  - if dac_busy=0, assert dac_start for 1 cycle in the same cycle value updates, latch dac_data = new value, go to BUSY;
  - otherwise go to PEND.
- PEND: wait for dac_busy=0, then pulse dac_start with dac_data = current value and go to BUSY. Further presses in PEND only update value; the single pending write carries the latest value.
- BUSY: wait for dac_busy to be seen high and then low. Return to IDLE, or to PEND if presses arrived meanwhile. If busy is not seen high within 4 cycles of dac_start, return to IDLE (writer absent or fast).
- dac_start never asserts while dac_busy=1. There is at most one dac_start per write.

Latency:
- From the first clock edge at which the raw button is sampled high (held steadily) to the press pulse: DEBOUNCE_CYCLES+3 cycles.
- dac_start (idle, not busy) follows the press pulse by one cycle.

Test Plan:
- Reset, then hold BTN_EAST high for 50 cycles (DEBOUNCE_CYCLES=16) -> exactly one east_press; value 0x800->0x900; one dac_start with dac_data=0x900, DEBOUNCE_CYCLES+4 cycles after the press edge.
- BTN_WEST glitch: high for 10 cycles, low for 5, high for 10, low -> no west_press, no dac_start, value stays 0x800.
- Thirteen east presses from reset (value 0x800) -> after the 8th press value=0xFFF and it stays there; dac_start is issued for every press, with dac_data=0xFFF on presses 8-13. Then 16 west presses -> value reaches 0x000 and stays.
- Hold dac_busy high and make 3 west presses -> value=0x500, no dac_start. Drop dac_busy -> exactly one dac_start with dac_data=0x500.
- Both buttons rise on the same cycle and hold for 50 cycles -> both press pulses coincide, value unchanged, no dac_start.
- Assert RST for 1 cycle mid-debounce of BTN_EAST and while in PEND -> all outputs return to reset values, no dac_start afterwards; a press after reset starts debounce from count 0.
